// File: rtl/uart_sdram_ctrl.sv
// uart_sdram_ctrl
// Command sequencer between the UART byte stream and the SDRAM read/write ports.
//   CMD_WR + BURST_LEN payload bytes -> buffered, then pushed to SDRAM as one burst.
//   CMD_RD -> one SDRAM read burst, replayed through uart_tx at TX_GAP spacing.
// Ports:
//   clk, rst_n                 : system clock, async active-low reset
//   rx_data, po_flag           : received UART byte and its valid strobe
//   tx_trig, tx_data           : start pulse and byte for uart_tx
//   wr_req/wr_ack/wr_data_req/wr_data/wr_done : SDRAM write burst handshake
//   rd_req/rd_ack/rd_data_vld/rd_data/rd_done : SDRAM read burst handshake
//   busy                       : high whenever the sequencer is not idle
//   err_drop                   : one-cycle pulse for a discarded/aborted byte
module uart_sdram_ctrl #(
    parameter int          BURST_LEN  = 4,
    parameter int          TX_GAP     = 52100,
    parameter int          RX_TIMEOUT = 520000,
    parameter logic [7:0]  CMD_WR     = 8'h55,
    parameter logic [7:0]  CMD_RD     = 8'hAA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       po_flag,
    output logic       tx_trig,
    output logic [7:0] tx_data,
    output logic       wr_req,
    input  logic       wr_ack,
    input  logic       wr_data_req,
    output logic [7:0] wr_data,
    input  logic       wr_done,
    output logic       rd_req,
    input  logic       rd_ack,
    input  logic       rd_data_vld,
    input  logic [7:0] rd_data,
    input  logic       rd_done,
    output logic       busy,
    output logic       err_drop
);

    localparam int ADDR_W  = $clog2(BURST_LEN);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int CNT_MAX = (TX_GAP > RX_TIMEOUT) ? TX_GAP : RX_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(BURST_LEN - 1);
    localparam logic [PTR_W-1:0]  PTR_FULL = PTR_W'(BURST_LEN);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_END  = CNT_W'(TX_GAP - 1);
    // The abort fires on the edge at which the idle counter would reach
    // RX_TIMEOUT-1, i.e. RX_TIMEOUT cycles after the last accepted byte.
    localparam logic [CNT_W-1:0]  TO_END   = CNT_W'(RX_TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE, WR_COLLECT, WR_REQ, WR_BURST, RD_REQ, RD_BURST, TX_SEND
    } state_t;

    state_t            state_reg, state_next;
    logic [PTR_W-1:0]  ptr_reg, ptr_next;
    logic [PTR_W-1:0]  n_reg, n_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              tx_trig_reg, tx_trig_next;
    logic [7:0]        tx_data_reg, tx_data_next;
    logic              err_drop_reg, err_drop_next;
    logic              wr_req_reg, rd_req_reg;

    logic [7:0]        buf_mem [0:BURST_LEN-1];
    logic              buf_we;
    logic [ADDR_W-1:0] buf_waddr;
    logic [7:0]        buf_wdata;

    logic [ADDR_W-1:0] ptr_idx, wr_idx;
    logic              rd_store;

    assign ptr_idx = ptr_reg[ADDR_W-1:0];
    // Write pointer saturates so the SDRAM side always sees a valid entry.
    assign wr_idx  = (ptr_reg > PTR_LAST) ? IDX_LAST : ptr_idx;
    assign rd_store = rd_data_vld && (ptr_reg < PTR_FULL);

    // Buffer storage: contents survive reset but are always refilled before use.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buf_mem[buf_waddr] <= buf_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            n_reg        <= '0;
            cnt_reg      <= '0;
            tx_trig_reg  <= 1'b0;
            tx_data_reg  <= 8'h00;
            err_drop_reg <= 1'b0;
            wr_req_reg   <= 1'b0;
            rd_req_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            n_reg        <= n_next;
            cnt_reg      <= cnt_next;
            tx_trig_reg  <= tx_trig_next;
            tx_data_reg  <= tx_data_next;
            err_drop_reg <= err_drop_next;
            wr_req_reg   <= (state_next == WR_REQ);
            rd_req_reg   <= (state_next == RD_REQ);
        end
    end

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        n_next        = n_reg;
        cnt_next      = cnt_reg;
        tx_trig_next  = 1'b0;
        tx_data_next  = tx_data_reg;
        err_drop_next = 1'b0;
        buf_we        = 1'b0;
        buf_waddr     = ptr_idx;
        buf_wdata     = rx_data;

        case (state_reg)
            IDLE: begin
                if (po_flag) begin
                    if (rx_data == CMD_WR) begin
                        ptr_next   = '0;
                        cnt_next   = '0;
                        state_next = WR_COLLECT;
                    end else if (rx_data == CMD_RD) begin
                        ptr_next   = '0;
                        state_next = RD_REQ;
                    end
                end
            end
            WR_COLLECT: begin
                if (po_flag) begin
                    buf_we   = 1'b1;
                    ptr_next = ptr_reg + PTR_W'(1);
                    cnt_next = '0;
                    if (ptr_reg == PTR_LAST) begin
                        state_next = WR_REQ;
                    end
                end else if (cnt_reg == TO_END) begin
                    cnt_next      = '0;
                    err_drop_next = 1'b1;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WR_REQ: begin
                if (wr_ack) begin
                    ptr_next   = '0;
                    state_next = WR_BURST;
                end
            end
            WR_BURST: begin
                if (wr_data_req && (ptr_reg < PTR_LAST)) begin
                    ptr_next = ptr_reg + PTR_W'(1);
                end
                if (wr_done) begin
                    state_next = IDLE;
                end
            end
            RD_REQ: begin
                if (rd_ack) begin
                    ptr_next   = '0;
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                buf_wdata = rd_data;
                if (rd_store) begin
                    buf_we   = 1'b1;
                    ptr_next = ptr_reg + PTR_W'(1);
                end
                if (rd_done) begin
                    // A beat arriving with rd_done is stored and counted.
                    n_next = rd_store ? (ptr_reg + PTR_W'(1)) : ptr_reg;
                    if (n_next == '0) begin
                        ptr_next   = '0;
                        state_next = IDLE;
                    end else begin
                        // The counter is logically at TX_GAP-1 here, so byte 0
                        // leaves on this edge; forward rd_data if it is byte 0.
                        tx_trig_next = 1'b1;
                        tx_data_next = (rd_store && (ptr_reg == '0)) ? rd_data : buf_mem[0];
                        ptr_next     = PTR_W'(1);
                        cnt_next     = '0;
                        state_next   = TX_SEND;
                    end
                end
            end
            TX_SEND: begin
                if (cnt_reg == GAP_END) begin
                    cnt_next = '0;
                    if (ptr_reg < n_reg) begin
                        tx_trig_next = 1'b1;
                        tx_data_next = buf_mem[ptr_idx];
                        ptr_next     = ptr_reg + PTR_W'(1);
                    end else begin
                        // Leaving only after a full gap protects the next frame.
                        ptr_next   = '0;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Bytes arriving while the sequencer is occupied are discarded.
        if (po_flag && (state_reg != IDLE) && (state_reg != WR_COLLECT)) begin
            err_drop_next = 1'b1;
        end
    end

    assign tx_trig  = tx_trig_reg;
    assign tx_data  = tx_data_reg;
    assign wr_req   = wr_req_reg;
    assign rd_req   = rd_req_reg;
    assign err_drop = err_drop_reg;
    assign busy     = (state_reg != IDLE);
    assign wr_data  = buf_mem[wr_idx];

endmodule

// File: tb/tb_uart_sdram_ctrl.sv
// Scoreboard bench for uart_sdram_ctrl (BURST_LEN=4, TX_GAP=20, RX_TIMEOUT=100).
module tb_uart_sdram_ctrl;

    localparam int BL  = 4;
    localparam int GAP = 20;
    localparam int TO  = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       po_flag = 1'b0;
    logic       tx_trig;
    logic [7:0] tx_data;
    logic       wr_req;
    logic       wr_ack = 1'b0;
    logic       wr_data_req = 1'b0;
    logic [7:0] wr_data;
    logic       wr_done = 1'b0;
    logic       rd_req;
    logic       rd_ack = 1'b0;
    logic       rd_data_vld = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic       rd_done = 1'b0;
    logic       busy;
    logic       err_drop;

    uart_sdram_ctrl #(
        .BURST_LEN(BL), .TX_GAP(GAP), .RX_TIMEOUT(TO),
        .CMD_WR(8'h55), .CMD_RD(8'hAA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .po_flag(po_flag),
        .tx_trig(tx_trig), .tx_data(tx_data),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_data_req(wr_data_req),
        .wr_data(wr_data), .wr_done(wr_done),
        .rd_req(rd_req), .rd_ack(rd_ack), .rd_data_vld(rd_data_vld),
        .rd_data(rd_data), .rd_done(rd_done),
        .busy(busy), .err_drop(err_drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    typedef struct {
        int         at;
        logic [7:0] data;
    } ev_t;

    ev_t        tx_q[$];
    int         drop_q[$];
    int         wrreq_q[$];
    int         rdreq_q[$];
    int         busy_q[$];
    logic [7:0] wd_q[$];

    ev_t  e_tx;
    logic busy_prev = 1'b0;
    logic wr_req_prev = 1'b0;
    logic rd_req_prev = 1'b0;

    // Monitor: compares every observed DUT event against the scoreboard queues.
    always @(negedge clk) begin
        if (tx_trig === 1'b1) begin
            if (tx_q.size() == 0) unexpected("tx_trig");
            else begin
                e_tx = tx_q.pop_front();
                check("tx_cycle", cyc, e_tx.at);
                check("tx_data", {24'h0, tx_data}, {24'h0, e_tx.data});
                $display("tx byte %02h at cycle %0d", tx_data, cyc);
            end
        end
        if (err_drop === 1'b1) begin
            if (drop_q.size() == 0) unexpected("err_drop");
            else begin
                check("drop_cycle", cyc, drop_q.pop_front());
                $display("err_drop at cycle %0d", cyc);
            end
        end
        if (wr_req === 1'b1 && wr_req_prev === 1'b0) begin
            if (wrreq_q.size() == 0) unexpected("wr_req");
            else begin
                check("wr_req_cycle", cyc, wrreq_q.pop_front());
                $display("wr_req rise at cycle %0d", cyc);
            end
        end
        if (rd_req === 1'b1 && rd_req_prev === 1'b0) begin
            if (rdreq_q.size() == 0) unexpected("rd_req");
            else begin
                check("rd_req_cycle", cyc, rdreq_q.pop_front());
                $display("rd_req rise at cycle %0d", cyc);
            end
        end
        if (busy === 1'b0 && busy_prev === 1'b1) begin
            if (busy_q.size() == 0) unexpected("busy_fall");
            else begin
                check("busy_fall_cycle", cyc, busy_q.pop_front());
                $display("busy fall at cycle %0d", cyc);
            end
        end
        if (wr_data_req && rst_n) begin
            if (wd_q.size() == 0) unexpected("wr_data_req");
            else begin
                check("wr_data", {24'h0, wr_data}, {24'h0, wd_q.pop_front()});
                $display("wr_data %02h at cycle %0d", wr_data, cyc);
            end
        end
        busy_prev   <= busy;
        wr_req_prev <= wr_req;
        rd_req_prev <= rd_req;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output int t);
        rx_data = b;
        po_flag = 1'b1;
        t = cyc;
        tick();
        po_flag = 1'b0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_tx_trig"},  {31'h0, tx_trig},  32'h0);
        check({tag, "_tx_data"},  {24'h0, tx_data},  32'h0);
        check({tag, "_wr_req"},   {31'h0, wr_req},   32'h0);
        check({tag, "_rd_req"},   {31'h0, rd_req},   32'h0);
        check({tag, "_busy"},     {31'h0, busy},     32'h0);
        check({tag, "_err_drop"}, {31'h0, err_drop}, 32'h0);
    endtask

    // Write frame; rst_in_burst resets the DUT after the first wr_data_req.
    task automatic write_frame(input logic [7:0] d [4], input bit rst_in_burst);
        int t;
        send_byte(8'h55, t);
        check("busy_after_wr_cmd", {31'h0, busy}, 32'h1);
        for (int i = 0; i < BL; i++) begin
            send_byte(d[i], t);
        end
        wrreq_q.push_back(t + 1);
        tick(2);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        check("wr_req_low_after_ack", {31'h0, wr_req}, 32'h0);
        for (int i = 0; i < BL; i++) begin
            wd_q.push_back(d[i]);
            wr_data_req = 1'b1;
            tick();
            wr_data_req = 1'b0;
            if (rst_in_burst) begin
                busy_q.push_back(cyc);
                rst_n = 1'b0;
                #1;
                reset_checks("rst_wr_burst");
                tick(2);
                rst_n = 1'b1;
                tick();
                return;
            end
            tick();
        end
        // Extra strobe beyond the burst, coinciding with wr_done: pointer stays on the last entry.
        wd_q.push_back(d[BL-1]);
        wr_data_req = 1'b1;
        wr_done = 1'b1;
        busy_q.push_back(cyc + 1);
        tick();
        wr_data_req = 1'b0;
        wr_done = 1'b0;
        tick(2);
        check("busy_after_wr_done", {31'h0, busy}, 32'h0);
    endtask

    // Read frame; drop_off/rst_off are cycle offsets from rd_done (0 = none).
    task automatic read_frame(input logic [7:0] beats [6], input int nbeats, input bit done_last,
                              input int drop_off, input int rst_off);
        int  t, d, nt, stop_at, dummy;
        ev_t ev;
        send_byte(8'hAA, t);
        rdreq_q.push_back(t + 1);
        check("busy_after_rd_cmd", {31'h0, busy}, 32'h1);
        tick(2);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        check("rd_req_low_after_ack", {31'h0, rd_req}, 32'h0);
        nt = (nbeats > BL) ? BL : nbeats;
        d = 0;
        for (int i = 0; i < nbeats; i++) begin
            rd_data = beats[i];
            rd_data_vld = 1'b1;
            if (done_last && i == nbeats - 1) begin
                rd_done = 1'b1;
                d = cyc;
            end
            tick();
            rd_data_vld = 1'b0;
            rd_done = 1'b0;
        end
        if (!done_last) begin
            rd_done = 1'b1;
            d = cyc;
            tick();
            rd_done = 1'b0;
        end
        for (int k = 0; k < nt; k++) begin
            ev.at = d + 1 + GAP * k;
            ev.data = beats[k];
            if (rst_off == 0 || ev.at < d + rst_off) tx_q.push_back(ev);
        end
        if (rst_off == 0) busy_q.push_back(d + 1 + GAP * nt);
        stop_at = d + GAP * nt + 5;
        while (cyc < stop_at) begin
            if (drop_off != 0 && cyc == d + drop_off) begin
                drop_q.push_back(cyc + 1);
                send_byte(8'h99, dummy);
            end else if (rst_off != 0 && cyc == d + rst_off) begin
                busy_q.push_back(cyc);
                rst_n = 1'b0;
                #1;
                reset_checks("rst_tx_send");
                tick(2);
                rst_n = 1'b1;
                tick();
            end else begin
                tick();
            end
        end
        check("busy_after_read", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        logic [7:0] wd [4];
        logic [7:0] rb [6];
        int t;

        rst_n = 1'b0;
        tick(3);
        reset_checks("reset");
        rst_n = 1'b1;
        tick(2);

        // Unknown byte in IDLE is ignored silently.
        send_byte(8'h7E, t);
        tick(3);
        check("busy_after_7e", {31'h0, busy}, 32'h0);

        wd = '{8'h11, 8'h22, 8'h33, 8'h44};
        write_frame(wd, 1'b0);

        rb = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00};
        read_frame(rb, 4, 1'b0, 10, 0);

        // Overrun: six beats, the sixth together with rd_done.
        rb = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        read_frame(rb, 6, 1'b1, 0, 0);

        // Single beat arriving with rd_done is still sent.
        rb = '{8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        read_frame(rb, 1, 1'b1, 0, 0);

        // Timeout: 55 01 02 then silence.
        send_byte(8'h55, t);
        send_byte(8'h01, t);
        send_byte(8'h02, t);
        drop_q.push_back(t + TO);
        busy_q.push_back(t + TO);
        tick(TO + 10);
        check("busy_after_timeout", {31'h0, busy}, 32'h0);

        // Reset during WR_BURST, then during TX_SEND, then a normal frame.
        wd = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        write_frame(wd, 1'b1);
        rb = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'h00, 8'h00};
        read_frame(rb, 4, 1'b0, 0, 30);
        wd = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
        write_frame(wd, 1'b0);

        tick(5);
        check("tx_q_left",    tx_q.size(),    0);
        check("drop_q_left",  drop_q.size(),  0);
        check("wrreq_q_left", wrreq_q.size(), 0);
        check("rdreq_q_left", rdreq_q.size(), 0);
        check("busy_q_left",  busy_q.size(),  0);
        check("wd_q_left",    wd_q.size(),    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_sdram_ctrl.md
# uart_sdram_ctrl

Command sequencer between the UART byte stream and the SDRAM controller. It sits between `uart_rx`/`uart_tx` and the SDRAM read/write ports, replacing the direct rx-to-tx loopback. A write command buffers a fixed-length burst from UART and pushes it into SDRAM. A read command fetches a burst from SDRAM and paces it back out through `uart_tx`.

## Interface
- `BURST_LEN`, 4: bytes per write/read burst (2..16).
- `TX_GAP`, 52100: clk cycles between successive `tx_trig` pulses; at least one UART frame time.
- `RX_TIMEOUT`, 520000: idle clk cycles allowed between payload bytes before a write command is aborted.
- `CMD_WR`, 8'h55: write command byte.
- `CMD_RD`, 8'hAA: read command byte.

Ports:
- `clk` in 1: system clock from PLL c0.
- `rst_n` in 1: reset; asynchronous, active-low (PLL locked).
- `rx_data` in 8: received byte.
- `po_flag` in 1: one-cycle strobe, `rx_data` valid.
- `tx_trig` out 1: one-cycle start pulse to `uart_tx`.
- `tx_data` out 8: byte to send; stable from `tx_trig` until the next `tx_trig`.
- `wr_req` out 1: write burst request; held high until `wr_ack`.
- `wr_ack` in 1: one-cycle acceptance of `wr_req`.
- `wr_data_req` in 1: per-beat strobe from the SDRAM controller consuming `wr_data`.
- `wr_data` out 8: `buf[wr_ptr]`, combinational from the buffer.
- `wr_done` in 1: one-cycle strobe, burst finished.
- `rd_req` out 1: read burst request; held high until `rd_ack`.
- `rd_ack` in 1: one-cycle acceptance of `rd_req`.
- `rd_data_vld` in 1: read beat valid.
- `rd_data` in 8: read beat.
- `rd_done` in 1: one-cycle strobe, read burst finished.
- `busy` out 1: high in every state except IDLE.
- `err_drop` out 1: one-cycle pulse when a received byte is discarded.

## Operation
- Storage: buffer `buf[0:BURST_LEN-1]` of 8-bit entries, one pointer `ptr` (`$clog2(BURST_LEN)+1` bits), one gap/timeout counter sized for the larger of `TX_GAP` and `RX_TIMEOUT`.
- **IDLE**
  - `po_flag` with `CMD_WR`: clear `ptr` and the counter, go to WR_COLLECT.
  - `po_flag` with `CMD_RD`: clear `ptr`, go to RD_REQ.
  - `po_flag` with any other byte: ignore silently, no `err_drop`.
- **WR_COLLECT**
  - On `po_flag`: write `buf[ptr]`, increment `ptr`, clear the counter.
  - When `ptr` reaches `BURST_LEN`: go to WR_REQ.
  - When the counter reaches `RX_TIMEOUT-1` with no byte: abort to IDLE, pulse `err_drop`, SDRAM untouched.
- **WR_REQ**: `wr_req`=1. On `wr_ack`: clear `ptr`, go to WR_BURST.
- **WR_BURST**
  - Each `wr_data_req` increments `ptr`.
  - `wr_data` always equals `buf[ptr]`; pointer saturates at `BURST_LEN-1`.
  - `wr_done`: go to IDLE.
- **RD_REQ**: `rd_req`=1. On `rd_ack`: clear `ptr`, go to RD_BURST.
- **RD_BURST**
  - Each `rd_data_vld` stores `buf[ptr]` and increments `ptr`.
  - Beats beyond `BURST_LEN` are discarded.
  - `rd_done`: latch `ptr` as count `n`, clear `ptr`, go to TX_SEND with the counter preset to `TX_GAP-1`, so the first byte goes out next cycle.
  - If `n`=0, go to IDLE instead.
- **TX_SEND**
  - When the counter hits `TX_GAP-1`: pulse `tx_trig`, register `tx_data`=`buf[ptr]`, increment `ptr`, clear the counter.
  - After `n` bytes sent: go to IDLE once the counter next reaches `TX_GAP-1`. This guarantees a full gap before any future transmit.
- Dropped bytes: `po_flag` in WR_REQ, WR_BURST, RD_REQ, RD_BURST or TX_SEND discards the byte and pulses `err_drop` the following cycle.
- Mid-operation reset: any state returns immediately to IDLE. Buffer contents are not cleared, but are never read without being refilled first.

## Timing
- Reset values: `tx_trig`=0, `tx_data`=8'h00, `wr_req`=0, `rd_req`=0, `busy`=0, `err_drop`=0, state IDLE, `ptr`=0, counter=0.
- All outputs are registered except `wr_data` (combinational from the buffer) and `busy` (decoded from state).
- Command byte to `busy`: 1 cycle.
- Last payload byte strobe to `wr_req` high: 1 cycle.
- `wr_ack` to `wr_req` low: 1 cycle. `rd_ack` to `rd_req` low: 1 cycle.
- `rd_done` to first `tx_trig`: 1 cycle. Subsequent `tx_trig` spacing: exactly `TX_GAP` cycles.
- `rd_data_vld` and `rd_done` in the same cycle: store the beat first, then count it in `n`.
- `wr_data_req` and `wr_done` in the same cycle: both take effect; state goes to IDLE.
- `po_flag` in the same cycle the FSM returns to IDLE: treated as dropped, not as a command.

## Test plan
- Write burst: with `BURST_LEN`=4, send 55 11 22 33 44 -> `wr_req` rises 1 cycle after 44. After `wr_ack`, four `wr_data_req` strobes see `wr_data` = 11, 22, 33, 44. `wr_done` -> IDLE, `busy`=0.
- Read burst: with `TX_GAP`=20, send AA -> `rd_req` rises. Return beats A1 B2 C3 D4, then `rd_done` -> `tx_trig` at +1, +21, +41, +61 cycles with `tx_data` A1, B2, C3, D4. `busy` falls at +81.
- Timeout: with `RX_TIMEOUT`=100, send 55 01 02 then silence -> `err_drop` pulses 100 cycles after 02. No `wr_req`, state IDLE.
- Drop and ignore: byte 7E in IDLE -> no response. Byte 99 during TX_SEND -> `err_drop` pulse; transmitted sequence unchanged.
- Overrun: 6 `rd_data_vld` beats for `BURST_LEN`=4 -> only the first 4 bytes are transmitted.
- Reset: assert `rst_n`=0 during WR_BURST and during TX_SEND -> all outputs take their reset values immediately. After release, the next 55-frame completes normally.
